// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity constants and frame sizing helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;
  function automatic int unsigned frame_bits(int unsigned data_width, logic par_en, logic stop2);
    return 32'd2 + data_width + {31'd0, par_en} + {31'd0, stop2};
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with registered full/empty flags and occupancy count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  logic [AW:0] count_nxt;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign count_nxt = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count_nxt;
      full <= count_nxt == (AW+1)'(DEPTH);
      empty <= count_nxt == '0;
    end
endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with input FIFO and per-frame latched config
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  input  logic                          par_en,
  input  logic                          par_typ,
  input  logic                          stop2,
  input  logic                          data_valid,
  input  logic [DATA_WIDTH-1:0]         p_data,
  output logic                          data_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);
  tx_state_t state;
  logic [DATA_WIDTH-1:0] sh, fifo_rdata;
  logic [DIV_WIDTH-1:0] div_l, cnt;
  logic [BW-1:0] bit_cnt;
  logic par_l, stop2_l, par_bit;
  logic fifo_full, fifo_empty;
  logic bit_end, stop_done, pop;
  assign bit_end = cnt == div_l;
  assign stop_done = state == STOP && bit_end && (!stop2_l || bit_cnt != '0);
  assign pop = !fifo_empty && (state == IDLE || stop_done);
  assign data_ready = !fifo_full;
  uart_tx_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(data_valid),
    .pop(pop),
    .wdata(p_data),
    .rdata(fifo_rdata),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      sh <= '0;
      div_l <= '0;
      cnt <= '0;
      bit_cnt <= '0;
      par_l <= 1'b0;
      stop2_l <= 1'b0;
      par_bit <= 1'b0;
      tx_out <= 1'b1;
      busy <= 1'b0;
    end else begin
      cnt <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: ;
        START:
          if (bit_end) begin
            state <= DATA;
            tx_out <= sh[0];
            sh <= sh >> 1;
            bit_cnt <= '0;
          end
        DATA:
          if (bit_end) begin
            if (bit_cnt == LAST) begin
              state <= par_l ? PARITY : STOP;
              tx_out <= par_l ? par_bit : 1'b1;
              bit_cnt <= '0;
            end else begin
              tx_out <= sh[0];
              sh <= sh >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        PARITY:
          if (bit_end) begin
            state <= STOP;
            tx_out <= 1'b1;
            bit_cnt <= '0;
          end
        STOP:
          if (bit_end) begin
            if (stop2_l && bit_cnt == '0) bit_cnt <= BW'(1);
            else begin
              state <= IDLE;
              busy <= 1'b0;
            end
          end
        default: state <= IDLE;
      endcase
      // a pop starts the next frame and overrides any idle transition above
      if (pop) begin
        state <= START;
        tx_out <= 1'b0;
        busy <= 1'b1;
        sh <= fifo_rdata;
        div_l <= baud_div;
        par_l <= par_en;
        stop2_l <= stop2;
        par_bit <= (^fifo_rdata) ^ (par_typ != PAR_EVEN);
        bit_cnt <= '0;
      end
    end
endmodule
